// File: rtl/spi_master.sv
// SPI mode-0 byte initiator: MSB-first full-duplex transfer with divided mclk,
// slow cs framing for oversampling slaves, and an optional cs-hold mode across bytes.
module spi_master #(
    parameter int unsigned CLKDIV   = 4,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_HOLD  = 4,
    parameter int unsigned CS_IDLE  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] txdata,
    input  logic       hold,
    input  logic       release_req,
    output logic       ready,
    output logic       done,
    output logic [7:0] rxdata,
    output logic       mclk,
    output logic       mosi,
    output logic       cs,
    input  logic       miso
);

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, HOLDT, HELD} state_t;

    localparam logic [7:0] DIV_LAST   = 8'(CLKDIV - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0] IDLE_MIN   = 8'(CS_IDLE);

    state_t     state, state_d;
    logic [7:0] cnt, cnt_d;
    logic [2:0] bitcnt, bitcnt_d;
    logic [6:0] tx_sr, tx_sr_d;
    logic [7:0] rx_sr, rx_sr_d;
    logic [7:0] idle_cnt, idle_cnt_d;
    logic       hold_q, hold_q_d;
    logic       ready_d, done_d, mclk_d, mosi_d, cs_d;
    logic [7:0] rxdata_d;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        bitcnt_d   = bitcnt;
        tx_sr_d    = tx_sr;
        rx_sr_d    = rx_sr;
        idle_cnt_d = idle_cnt;
        hold_q_d   = hold_q;
        ready_d    = 1'b0;
        done_d     = 1'b0;
        rxdata_d   = rxdata;
        mclk_d     = mclk;
        mosi_d     = mosi;
        cs_d       = cs;

        case (state)
            IDLE: begin
                cs_d   = 1'b1;
                mclk_d = 1'b0;
                if (start && ready) begin
                    state_d  = SETUP;
                    cnt_d    = SETUP_LAST;
                    cs_d     = 1'b0;
                    mosi_d   = txdata[7];
                    tx_sr_d  = txdata[6:0];
                    hold_q_d = hold;
                    bitcnt_d = '0;
                end else begin
                    if (idle_cnt != '1)
                        idle_cnt_d = idle_cnt + 8'd1;
                    ready_d = (idle_cnt_d >= IDLE_MIN);
                end
            end

            SETUP: begin
                if (cnt == '0) begin
                    state_d = HIGH;
                    cnt_d   = DIV_LAST;
                    mclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end

            HIGH: begin
                if (cnt == '0) begin
                    // Sampling at the end of the high phase gives a slow slave time to settle miso.
                    rx_sr_d = {rx_sr[6:0], miso};
                    mclk_d  = 1'b0;
                    if (bitcnt == 3'd7) begin
                        state_d = HOLDT;
                        cnt_d   = HOLD_LAST;
                    end else begin
                        state_d  = LOW;
                        cnt_d    = DIV_LAST;
                        mosi_d   = tx_sr[6];
                        tx_sr_d  = {tx_sr[5:0], 1'b0};
                        bitcnt_d = bitcnt + 3'd1;
                    end
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end

            LOW: begin
                if (cnt == '0) begin
                    state_d = HIGH;
                    cnt_d   = DIV_LAST;
                    mclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end

            HOLDT: begin
                if (cnt == '0) begin
                    done_d   = 1'b1;
                    rxdata_d = rx_sr;
                    if (hold_q) begin
                        state_d = HELD;
                        ready_d = 1'b1;
                    end else begin
                        state_d    = IDLE;
                        cs_d       = 1'b1;
                        idle_cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt - 8'd1;
                end
            end

            HELD: begin
                cs_d   = 1'b0;
                mclk_d = 1'b0;
                // The first low phase doubles as setup time for the follow-on byte.
                if (start) begin
                    state_d  = LOW;
                    cnt_d    = DIV_LAST;
                    mosi_d   = txdata[7];
                    tx_sr_d  = txdata[6:0];
                    hold_q_d = hold;
                    bitcnt_d = '0;
                end else if (release_req) begin
                    state_d    = IDLE;
                    cs_d       = 1'b1;
                    idle_cnt_d = '0;
                end else begin
                    ready_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                mclk_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bitcnt   <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            idle_cnt <= '0;
            hold_q   <= 1'b0;
            ready    <= 1'b0;
            done     <= 1'b0;
            rxdata   <= '0;
            mclk     <= 1'b0;
            mosi     <= 1'b0;
            cs       <= 1'b1;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            bitcnt   <= bitcnt_d;
            tx_sr    <= tx_sr_d;
            rx_sr    <= rx_sr_d;
            idle_cnt <= idle_cnt_d;
            hold_q   <= hold_q_d;
            ready    <= ready_d;
            done     <= done_d;
            rxdata   <= rxdata_d;
            mclk     <= mclk_d;
            mosi     <= mosi_d;
            cs       <= cs_d;
        end
    end

endmodule
